// File: rtl/pipelined_accumulator_if.sv
// Scan-engine bus: start/config handshake, memory read port and result/status outputs.
interface pipelined_accumulator_if #(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 30,
   parameter int COUNT_W = 16
);
   logic               start;
   logic [ADDR_W-1:0]  base;
   logic [COUNT_W-1:0] length;
   logic [1:0]         mode;
   logic               stall;
   logic [ADDR_W-1:0]  mem_addr;
   logic [WIDTH-1:0]   mem_data;
   logic [WIDTH-1:0]   out;
   logic               busy;
   logic               done;
   logic               ovf;

   modport master (
      output start, base, length, mode, stall, mem_data,
      input  mem_addr, out, busy, done, ovf
   );

   modport slave (
      input  start, base, length, mode, stall, mem_data,
      output mem_addr, out, busy, done, ovf
   );
endinterface

// File: rtl/pipelined_accumulator.sv
// Memory-scan/checksum engine: fetches `length` words from `base` and folds them
// through a fetch register and an accumulate register with add/sub/xor/max.
//
// state | meaning
// IDLE  | waiting for start; a zero-length scan completes from here
// RUN   | fetching one word per unstalled cycle, accumulating the previous one
// DRAIN | last word in the operand register; final accumulate and done
module pipelined_accumulator #(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 30,
   parameter int COUNT_W = 16
) (
   input logic                    clk,
   input logic                    reset,
   pipelined_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q;
   logic [COUNT_W-1:0] rem_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   acc_nx;
   logic [1:0]         mode_q;
   logic               vld_q;
   logic               ovf_q;
   logic               done_q;
   logic               zpend_q;
   logic               step_ovf;
   logic               accept;

   // A pending zero-length completion blocks a new start for its one cycle.
   assign accept = (state_q == S_IDLE) && bus.start && !bus.stall && !zpend_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && (bus.length != '0)) state_d = S_RUN;
         end
         S_RUN: begin
            if (!bus.stall && (rem_q == COUNT_W'(1))) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!bus.stall) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_nx   = acc_q;
      step_ovf = 1'b0;
      case (mode_q)
         2'd0: begin
            acc_nx   = acc_q + opnd_q;
            step_ovf = (acc_q[WIDTH-1] == opnd_q[WIDTH-1]) && (acc_nx[WIDTH-1] != acc_q[WIDTH-1]);
         end
         2'd1: begin
            acc_nx   = acc_q - opnd_q;
            step_ovf = (acc_q[WIDTH-1] != opnd_q[WIDTH-1]) && (acc_nx[WIDTH-1] != acc_q[WIDTH-1]);
         end
         2'd2:    acc_nx = acc_q ^ opnd_q;
         default: acc_nx = (opnd_q > acc_q) ? opnd_q : acc_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         rem_q   <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         mode_q  <= 2'd0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         zpend_q <= 1'b0;
      end else if (!bus.stall) begin
         done_q <= 1'b0;
         if (vld_q) begin
            acc_q <= acc_nx;
            if (step_ovf) ovf_q <= 1'b1;
         end
         if (state_q == S_RUN) begin
            opnd_q <= bus.mem_data;
            vld_q  <= 1'b1;
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - COUNT_W'(1);
         end
         if (state_q == S_DRAIN) begin
            vld_q  <= 1'b0;
            done_q <= 1'b1;
         end
         if (zpend_q) begin
            zpend_q <= 1'b0;
            done_q  <= 1'b1;
         end
         if (accept) begin
            mode_q  <= bus.mode;
            addr_q  <= bus.base;
            rem_q   <= bus.length;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            zpend_q <= (bus.length == '0);
         end
      end
   end

   // done is held through stalls and only shown on an unstalled cycle.
   assign bus.mem_addr = addr_q;
   assign bus.out      = acc_q;
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = done_q & ~bus.stall;
   assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_pipelined_accumulator.sv
// Randomised bench for pipelined_accumulator against a fold-over-memory reference model.
module tb_pipelined_accumulator;
   localparam longint LIM = 64'sd2147483648;

   logic clk = 1'b0;
   logic reset = 1'b0;
   pipelined_accumulator_if bus ();
   pipelined_accumulator dut (.clk(clk), .reset(reset), .bus(bus));

   logic [31:0] mem [64];
   assign bus.mem_data = mem[bus.mem_addr[5:0]];

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference state shared by the driver and the compare process
   bit          active = 1'b0;
   int          k_g = 0;
   int          n_g = 0;
   logic [29:0] base_g = '0;
   logic [31:0] exp_res = '0;
   logic        exp_ovf = 1'b0;
   logic [31:0] last_out = '0;
   logic        last_ovf = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Fold the scanned words with plain arithmetic; overflow judged on true signed sums.
   function automatic void model(input logic [29:0] b, input int n, input logic [1:0] m,
                                 output logic [31:0] res, output logic ov);
      logic [29:0] a;
      logic [31:0] d;
      longint      s;
      res = '0;
      ov  = 1'b0;
      for (int i = 0; i < n; i++) begin
         a = b + 30'(i);
         d = mem[a[5:0]];
         case (m)
            2'd0: begin
               s = longint'($signed(res)) + longint'($signed(d));
               if (s >= LIM || s < -LIM) ov = 1'b1;
               res = res + d;
            end
            2'd1: begin
               s = longint'($signed(res)) - longint'($signed(d));
               if (s >= LIM || s < -LIM) ov = 1'b1;
               res = res - d;
            end
            2'd2:    res = res ^ d;
            default: if (d > res) res = d;
         endcase
      end
   endfunction

   // k_g counts unstalled edges since the accepting edge.
   always @(negedge clk) begin : cmp
      int mn;
      if (active) begin
         mn = (k_g < n_g) ? k_g : n_g;
         check("busy", bus.busy, (n_g > 0) && (k_g <= n_g));
         check("done", bus.done, (k_g == n_g + 1) && !bus.stall);
         check("mem_addr", bus.mem_addr, 30'(base_g + 30'(mn)));
         if (k_g == 0) begin
            check("out_cleared", bus.out, 32'h0);
            check("ovf_cleared", bus.ovf, 1'b0);
         end
         if ((k_g == n_g + 1) && !bus.stall) begin
            check("out_final", bus.out, exp_res);
            check("ovf_final", bus.ovf, exp_ovf);
            last_out = bus.out;
            last_ovf = bus.ovf;
         end
      end
   end

   task automatic run_scan(input logic [29:0] b, input int n, input logic [1:0] m,
                           input logic [63:0] smask, input bit xstart, output int cyc);
      bit fin;
      fin = 1'b0;
      cyc = -1;
      model(b, n, m, exp_res, exp_ovf);
      base_g   = b;
      n_g      = n;
      k_g      = 0;
      last_out = 32'hDEADBEEF;
      last_ovf = 1'b0;
      bus.base   = b;
      bus.length = 16'(n);
      bus.mode   = m;
      bus.stall  = 1'b0;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      active    = 1'b1;
      for (int j = 0; j < 200 && !fin; j++) begin
         bus.stall = (j < 64) ? smask[j] : 1'b0;
         bus.start = xstart && (n > 0) && (k_g <= n);
         @(negedge clk);
         if ((k_g == n + 1) && !bus.stall) begin
            fin = 1'b1;
            cyc = j;
         end
         @(posedge clk);
         #1;
         if (!bus.stall) k_g++;
      end
      active    = 1'b0;
      bus.stall = 1'b0;
      bus.start = 1'b0;
      check("scan_completed", fin, 1'b1);
   endtask

   initial begin
      int          cyc;
      logic [63:0] sm;

      bus.start  = 1'b0;
      bus.base   = '0;
      bus.length = '0;
      bus.mode   = 2'd0;
      bus.stall  = 1'b0;
      for (int i = 0; i < 64; i++) mem[i] = '0;

      #1;
      check("rst_out", bus.out, 32'h0);
      check("rst_mem_addr", bus.mem_addr, 30'h0);
      check("rst_done", bus.done, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_ovf", bus.ovf, 1'b0);
      #11 reset = 1'b1;
      @(posedge clk);
      #1;

      // add 1..4 from 0
      mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
      run_scan(30'h0, 4, 2'd0, 64'h0, 1'b0, cyc);
      check("add_out", last_out, 32'd10);
      check("add_ovf", last_ovf, 1'b0);
      check("add_latency", cyc, 5);

      // sub 5,3 from 8
      mem[8] = 32'd5; mem[9] = 32'd3;
      run_scan(30'h8, 2, 2'd1, 64'h0, 1'b0, cyc);
      check("sub_out", last_out, 32'hFFFF_FFF8);
      check("sub_ovf", last_ovf, 1'b0);

      // two stall cycles in mid-run plus start held while busy
      run_scan(30'h0, 4, 2'd0, 64'hC, 1'b1, cyc);
      check("stall_out", last_out, 32'd10);
      check("stall_latency", cyc, 7);

      // zero length
      run_scan(30'h5, 0, 2'd0, 64'h0, 1'b0, cyc);
      check("zero_out", last_out, 32'h0);
      check("zero_latency", cyc, 1);

      // address wrap with signed overflow
      mem[62] = 32'h7FFF_FFFF; mem[63] = 32'h1; mem[0] = 32'h0;
      run_scan(30'h3FFF_FFFE, 3, 2'd0, 64'h0, 1'b0, cyc);
      check("wrap_out", last_out, 32'h8000_0000);
      check("wrap_ovf", last_ovf, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ovf_sticky", bus.ovf, 1'b1);
      end
      @(posedge clk);
      #1;

      // asynchronous reset mid-run
      for (int i = 0; i < 8; i++) mem[20 + i] = 32'h11 * (i + 1);
      bus.base = 30'd20; bus.length = 16'd8; bus.mode = 2'd0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check("pre_reset_out_nonzero", (bus.out != 32'h0), 1'b1);
      reset = 1'b0;
      #1;
      check("mid_rst_out", bus.out, 32'h0);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_done", bus.done, 1'b0);
      check("mid_rst_mem_addr", bus.mem_addr, 30'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      mem[16] = 32'hF0; mem[17] = 32'h0F;
      run_scan(30'd16, 2, 2'd2, 64'h0, 1'b0, cyc);
      check("xor_out", last_out, 32'hFF);

      // randomised scans
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 64; i++) mem[i] = $urandom;
         sm = {$urandom, $urandom} & {$urandom, $urandom};
         run_scan(30'($urandom), int'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
                  sm, t[0], cyc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
